// File: rtl/fcircle_spans.sv
// Filled-circle span generator: midpoint circle walk, four horizontal spans per step.
// Latency: first span_start one cycle after start; backpressure: holds each span until span_done.
module fcircle_spans #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [CORDW-1:0] xc,
  input  logic signed [CORDW-1:0] yc,
  input  logic signed [CORDW-1:0] r,
  input  logic                    span_done,
  output logic signed [CORDW-1:0] span_x0,
  output logic signed [CORDW-1:0] span_x1,
  output logic signed [CORDW-1:0] span_y,
  output logic                    span_start,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = CORDW + 2;

  typedef enum logic [1:0] {IDLE, SPAN, WAIT, NEXT} state_t;

  state_t                  state, state_nxt;
  logic signed [CORDW-1:0] cx, cy, px, py;
  logic signed [CORDW-1:0] cx_nxt, cy_nxt, px_nxt, py_nxt;
  logic signed [CORDW-1:0] x0_nxt, x1_nxt, y_nxt, hx, vy;
  logic signed [DW-1:0]    d, d_nxt, pxe, pye, re;
  logic [1:0]              idx, idx_nxt;
  logic                    busy_nxt, done_nxt;

  assign pxe = {{2{px[CORDW-1]}}, px};
  assign pye = {{2{py[CORDW-1]}}, py};
  assign re  = {{2{r[CORDW-1]}}, r};

  assign span_start = (state == SPAN);

  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    px_nxt    = px;
    py_nxt    = py;
    d_nxt     = d;
    idx_nxt   = idx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    x0_nxt    = span_x0;
    x1_nxt    = span_x1;
    y_nxt     = span_y;

    case (state)
      IDLE: begin
        if (start) begin
          if (!r[CORDW-1]) begin
            cx_nxt    = xc;
            cy_nxt    = yc;
            px_nxt    = r;
            py_nxt    = '0;
            d_nxt     = DW'(1) - re;
            idx_nxt   = 2'd0;
            busy_nxt  = 1'b1;
            state_nxt = SPAN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SPAN: state_nxt = WAIT;
      WAIT: begin
        if (span_done) begin
          if (idx != 2'd3) begin
            idx_nxt   = idx + 2'd1;
            state_nxt = SPAN;
          end else begin
            state_nxt = NEXT;
          end
        end
      end
      NEXT: begin
        // Decision update uses the pre-step px/py.
        py_nxt = py + CORDW'(1);
        if (d[DW-1]) begin
          d_nxt = d + (pye <<< 1) + DW'(3);
        end else begin
          d_nxt  = d + ((pye - pxe) <<< 1) + DW'(5);
          px_nxt = px - CORDW'(1);
        end
        if (px_nxt >= py_nxt) begin
          idx_nxt   = 2'd0;
          state_nxt = SPAN;
        end else begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Octant pairs 2/3 swap the roles of px and py.
    hx = idx_nxt[1] ? py_nxt : px_nxt;
    vy = idx_nxt[1] ? px_nxt : py_nxt;
    if (state_nxt == SPAN) begin
      x0_nxt = cx_nxt - hx;
      x1_nxt = cx_nxt + hx;
      y_nxt  = idx_nxt[0] ? (cy_nxt - vy) : (cy_nxt + vy);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx      <= '0;
      cy      <= '0;
      px      <= '0;
      py      <= '0;
      d       <= '0;
      idx     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      span_x0 <= '0;
      span_x1 <= '0;
      span_y  <= '0;
    end else begin
      cx      <= cx_nxt;
      cy      <= cy_nxt;
      px      <= px_nxt;
      py      <= py_nxt;
      d       <= d_nxt;
      idx     <= idx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      span_x0 <= x0_nxt;
      span_x1 <= x1_nxt;
      span_y  <= y_nxt;
    end
  end

endmodule

// File: doc/fcircle_spans.md
# fcircle_spans

Filled-circle span generator for the 2D drawing engine. Runs the integer midpoint circle algorithm and breaks a filled circle into horizontal spans (x0, x1, y). It hands each span to the downstream fast line drawer through a start/done handshake. Sits directly upstream of the horizontal-line stage: span_x0/span_x1/span_start drive that stage's x0/x1/start, and that stage's done returns as span_done.

## Interface
- CORDW, default 16: signed coordinate width (bits).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a circle; sampled only in IDLE.
- xc, yc  in  CORDW signed  centre; latched on accepted start.
- r  in  CORDW signed  radius; latched on accepted start.
- span_done  in  1  downstream span complete (one-cycle pulse).
- span_x0, span_x1  out  CORDW signed  span endpoints; span_x0 <= span_x1 always.
- span_y  out  CORDW signed  span row.
- span_start  out  1  one-cycle request to the downstream stage.
- busy  out  1  circle in progress.
- done  out  1  circle complete; high for exactly one cycle.

## Operation
- State machine: IDLE, SPAN, WAIT, NEXT.
- Internal registers:
  - px, py: CORDW signed.
  - d: CORDW+2 signed decision term.
  - idx: 2-bit span index.
  - xc, yc: latched centre.
- IDLE, start=1, r>=0: latch xc, yc; px=r, py=0, d=1-r, idx=0, busy=1; go to SPAN.
- IDLE, start=1, r<0: no spans; busy stays 0; done=1 next cycle; stay IDLE.
- SPAN: span_start=1 (Moore, this state only). Span outputs are registered on entry and held stable through WAIT. Go to WAIT.
- Span contents by idx:
  - idx 0: y=yc+py, x0=xc-px, x1=xc+px.
  - idx 1: y=yc-py, x0=xc-px, x1=xc+px.
  - idx 2: y=yc+px, x0=xc-py, x1=xc+py.
  - idx 3: y=yc-px, x0=xc-py, x1=xc+py.
- WAIT, span_done=1: if idx<3, idx+=1 and go to SPAN; else go to NEXT.
- NEXT (using old px, py):
  - py+=1.
  - If d<0: d+=2*py+3.
  - Else: d+=2*(py-px)+5 and px-=1.
  - If new px >= new py: idx=0, go to SPAN.
  - Else: busy=0, done=1, go to IDLE.
- Duplicate spans (py=0 pair, px=py octant overlap) are emitted unchanged. Overdraw is accepted, and the span sequence is fully deterministic.
- Arithmetic: coordinate sums wrap modulo 2^CORDW; no clipping. d never overflows for r < 2^(CORDW-1).
- Ignored inputs:
  - start while busy.
  - span_done outside WAIT.

## Timing
- Reset (async assert): state=IDLE; busy=0, done=0, span_start=0, span_x0=span_x1=span_y=0, idx=0. Release is synchronous to clk.
- Reset mid-circle aborts immediately with no done pulse. The downstream stage shares rst_n.
- Start latency: start sampled at edge E → span_start high for cycle E..E+1; busy high from E.
- Span turnaround: span_done sampled at edge K:
  - idx<3: next span_start in cycle K..K+1.
  - idx=3: NEXT occupies K..K+1, and the next span_start is in K+1..K+2.
- Completion: termination in NEXT at edge T → busy=0 and done=1 for cycle T..T+1. A new start can be accepted at edge T+1.
- span_start never asserts while a previous span is outstanding (one span in flight).
- span_done arriving in the same cycle as span_start is not legal downstream behaviour; it is ignored.

## Test plan
- r=0, xc=10, yc=20: exactly 4 spans, each (x0=10, x1=10, y=20). done one cycle after the 4th span_done; busy then 0.
- r=1, xc=0, yc=0: spans in order (-1,1,0), (-1,1,0), (0,0,1), (0,0,-1), then done. NEXT yields px=0, py=1, d=3.
- r=5 at (100,50), span_done returned 1 cycle after each span_start:
  - Total spans = 4 × iterations.
  - Union of rows equals the reference midpoint fill model.
  - span_x0 <= span_x1 everywhere.
  - Cycle count matches the timing rules.
- r=-3: no span_start ever; done pulses one cycle after start; busy stays 0.
- Handshake abuse: start and spurious span_done pulses during WAIT/SPAN of an r=4 circle. Extra starts are ignored; spurious span_done outside WAIT is ignored. The span sequence is identical to the undisturbed run.
- rst_n low mid-WAIT of an r=8 circle: all outputs go to 0 asynchronously. After release, start with r=2 produces the correct full sequence from idx 0.
